// File: rtl/sseg_scan_if.sv
// sseg_scan_if
//   Bundles the multiplexed seven-segment scan bus (an/sseg/dp, active-low)
//   together with the decoded frame and status outputs of sseg_scan_decoder.
//   master : the side that drives the scan bus and consumes decoded frames
//   slave  : the decoder
// Signals
//   an[3:0]          anode enables, active-low, an[i]=0 selects digit i
//   sseg[6:0]        segments, active-low, {g,f,e,d,c,b,a}
//   dp               decimal point, active-low
//   digit0..digit3   decoded 4-bit code of each digit
//   blank_mask       bit i set: digit i was blank
//   dp_mask          bit i set: dp was lit while digit i was captured
//   err_mask         bit i set: digit i pattern was undecodable
//   frame_valid      1-cycle pulse, frame outputs just updated
//   pattern_err      1-cycle pulse on a capture with an undecodable pattern
//   anode_err        1-cycle pulse per registered cycle with >=2 anodes low
//   scan_lost        level, no capture for TIMEOUT_CYCLES cycles
interface sseg_scan_if;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] blank_mask;
  logic [3:0] dp_mask;
  logic [3:0] err_mask;
  logic       frame_valid;
  logic       pattern_err;
  logic       anode_err;
  logic       scan_lost;

  modport master (
    output an, sseg, dp,
    input  digit0, digit1, digit2, digit3,
    input  blank_mask, dp_mask, err_mask,
    input  frame_valid, pattern_err, anode_err, scan_lost
  );

  modport slave (
    input  an, sseg, dp,
    output digit0, digit1, digit2, digit3,
    output blank_mask, dp_mask, err_mask,
    output frame_valid, pattern_err, anode_err, scan_lost
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
//   Receive side of the 4-digit multiplexed seven-segment scan bus. Each digit
//   is sampled while its anode is active and settled, its segment pattern is
//   decoded back to a digit code, and complete 4-digit frames are published.
//   Scan faults (overlapping anodes, bad patterns, lost scan) are flagged.
// Parameters
//   SETTLE_CYCLES   cycles an must hold one one-hot-low value before capture (>=1)
//   TIMEOUT_CYCLES  cycles without any capture before scan_lost asserts (>=2)
// Configuration macro
//   SSEG_HEX_DECODE_EN  when defined, patterns for A,b,C,d,E,F decode to codes
//                       4'hA..4'hF; otherwise they are undecodable.
// Ports
//   clk    system clock, posedge
//   reset  asynchronous, active-high
//   bus    sseg_scan_if.slave (scan bus in, frame and status out)
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  sseg_scan_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] TIMEOUT_MAX = IW'(TIMEOUT_CYCLES);

  // Result packing: {err, blank, code[3:0]}
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b10_0000;
    case (s)
      7'h40: r = 6'h00;
      7'h79: r = 6'h01;
      7'h24: r = 6'h02;
      7'h30: r = 6'h03;
      7'h19: r = 6'h04;
      7'h12: r = 6'h05;
      7'h02: r = 6'h06;
      7'h78: r = 6'h07;
      7'h00: r = 6'h08;
      7'h10: r = 6'h09;
      7'h7F: r = 6'b01_0000;
`ifdef SSEG_HEX_DECODE_EN
      7'h08: r = 6'h0A;
      7'h03: r = 6'h0B;
      7'h46: r = 6'h0C;
      7'h21: r = 6'h0D;
      7'h06: r = 6'h0E;
      7'h0E: r = 6'h0F;
`endif
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // stage 1
  logic [3:0] an_q;
  logic [6:0] sseg_q;
  logic       dp_q;
  logic       anode_err_q;

  // settle / capture
  logic [SW-1:0] stable_cnt;
  logic          dwell_done;
  logic          capture;
  logic [1:0]    cap_idx;
  logic [3:0]    cap_bit;
  logic [5:0]    dec;

  // stage 2 shadow
  logic [3:0][3:0] sh_code;
  logic [3:0]      sh_blank;
  logic [3:0]      sh_dp;
  logic [3:0]      sh_err;
  logic [3:0]      cap_mask;
  logic            pattern_err_q;

  // stage 3 outputs
  logic [3:0][3:0] digit_q;
  logic [3:0]      blank_q;
  logic [3:0]      dpm_q;
  logic [3:0]      err_q;
  logic            frame_valid_q;

  logic [IW-1:0]   idle_cnt;

  // anode_err is judged on the incoming value so it lines up with the cycle
  // that value sits in an_q, without a false pulse from the reset value of an_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q        <= '0;
      sseg_q      <= '0;
      dp_q        <= 1'b0;
      anode_err_q <= 1'b0;
    end else begin
      an_q        <= bus.an;
      sseg_q      <= bus.sseg;
      dp_q        <= bus.dp;
      anode_err_q <= ($countones(~bus.an) >= 2);
    end
  end

  // dwell_done limits a dwell to one capture even after stable_cnt saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      dwell_done <= 1'b0;
    end else if (bus.an != an_q) begin
      stable_cnt <= SW'(1);
      dwell_done <= 1'b0;
    end else begin
      if (stable_cnt != SETTLE_MAX)
        stable_cnt <= stable_cnt + SW'(1);
      if (capture)
        dwell_done <= 1'b1;
    end
  end

  assign capture = $onehot(~an_q) && (stable_cnt == SETTLE_MAX) && !dwell_done;
  assign cap_bit = capture ? ~an_q : 4'h0;
  assign dec     = decode(sseg_q);

  always_comb begin
    cap_idx = 2'd0;
    case (an_q)
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_code       <= '0;
      sh_blank      <= '0;
      sh_dp         <= '0;
      sh_err        <= '0;
      cap_mask      <= '0;
      pattern_err_q <= 1'b0;
    end else begin
      pattern_err_q <= capture & dec[5];
      if (capture) begin
        sh_code[cap_idx]  <= dec[3:0];
        sh_blank[cap_idx] <= dec[4];
        sh_dp[cap_idx]    <= ~dp_q;
        sh_err[cap_idx]   <= dec[5];
      end
      // A capture landing while the full frame is being published starts the next frame.
      if (cap_mask == 4'hF)
        cap_mask <= cap_bit;
      else
        cap_mask <= cap_mask | cap_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q       <= '0;
      blank_q       <= '0;
      dpm_q         <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else if (cap_mask == 4'hF) begin
      digit_q       <= sh_code;
      blank_q       <= sh_blank;
      dpm_q         <= sh_dp;
      err_q         <= sh_err;
      frame_valid_q <= 1'b1;
    end else begin
      frame_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (capture)
      idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_MAX)
      idle_cnt <= idle_cnt + IW'(1);
  end

  assign bus.digit0      = digit_q[0];
  assign bus.digit1      = digit_q[1];
  assign bus.digit2      = digit_q[2];
  assign bus.digit3      = digit_q[3];
  assign bus.blank_mask  = blank_q;
  assign bus.dp_mask     = dpm_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.anode_err   = anode_err_q;
  assign bus.scan_lost   = (idle_cnt == TIMEOUT_MAX);

endmodule
